// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ---------------
// Sequences byte messages from two requesters onto one UART transmitter.
// Requester 0 is the DDS register controller and requester 1 is the
// command-echo path. Ownership is decided round-robin at message boundaries.
// The owner keeps the grant until its last byte has been sent, or until the
// message times out or is aborted.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   baud_tick         one-clk pulse per baud period (used only by the gap option)
//   req0/data0/last0  requester 0 byte offer; ack0 pulses when the byte is taken
//   req1/data1/last1  requester 1 byte offer; ack1 pulses when the byte is taken
//   tx_data/tx_start  byte and one-clk start pulse to the serializer
//   tx_busy           serializer is shifting a frame
//   grant             one-hot current owner, 00 = none
//   err               one-clk pulse on busy-rise timeout or mid-message abort
//
// Handshake: a requester holds req/data/last stable until the cycle its ack is
// high. The values seen during the ack cycle are the byte consumed, and the
// next byte may be offered from the following cycle. tx_start is high in the
// same cycle as the ack. tx_data is valid from that cycle and is held until
// the next byte is loaded.
//
// Build option: define UART_TX_ARB_GAP_EN to insert GAP_TICKS baud ticks of
// idle line after each frame before the next byte is considered.

module uart_tx_arbiter #(
  parameter int BUSY_WAIT_MAX = 16,
  parameter int GAP_TICKS     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       last0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       last1,
  output logic       ack1,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_RISE = 3'd2;
  localparam logic [2:0] S_WAIT_FALL = 3'd3;
  localparam logic [2:0] S_NEXT      = 3'd4;
`ifdef UART_TX_ARB_GAP_EN
  localparam logic [2:0] S_GAP       = 3'd5;
`endif

  // One counter serves both the busy-rise wait and the gap tick count.
  localparam int CNT_MAX = (BUSY_WAIT_MAX > GAP_TICKS) ? BUSY_WAIT_MAX : GAP_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          last_q;     // last flag of the byte currently in flight
  logic          ptr;        // requester favoured when both ask in IDLE
  logic          pick1;      // IDLE arbitration result: 1 = requester 1
  logic          load_sel;   // requester whose byte is loaded this edge
  logic          owner_req;
  logic          go_load;    // next state is LOAD; the byte is captured now

`ifndef UART_TX_ARB_GAP_EN
  logic unused_baud_tick;
  assign unused_baud_tick = baud_tick;
`endif

  always_comb begin
    pick1     = req1 & (~req0 | ptr);
    owner_req = grant[1] ? req1 : req0;
    load_sel  = grant[1];
    go_load   = 1'b0;
    if (state == S_IDLE) begin
      go_load  = req0 | req1;
      load_sel = pick1;
    end else if (state == S_NEXT) begin
      go_load  = ~last_q & owner_req;
    end
  end

  // The byte is captured on the edge that enters LOAD. This makes tx_data,
  // tx_start and the ack all appear together during the LOAD cycle. The
  // requester is still holding that same byte then, because it has not yet
  // seen its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= 8'h00;
      last_q   <= 1'b0;
      tx_start <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
    end else begin
      tx_start <= go_load;
      ack0     <= go_load & ~load_sel;
      ack1     <= go_load & load_sel;
      if (go_load) begin
        tx_data <= load_sel ? data1 : data0;
        last_q  <= load_sel ? last1 : last0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      grant <= 2'b00;
      ptr   <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go_load) begin
            grant <= pick1 ? 2'b10 : 2'b01;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          state <= S_WAIT_RISE;
        end
        S_WAIT_RISE: begin
          if (tx_busy) begin
            state <= S_WAIT_FALL;
          end else if (cnt == CW'(BUSY_WAIT_MAX - 1)) begin
            err   <= 1'b1;
            grant <= 2'b00;
            ptr   <= ~ptr;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_FALL: begin
          if (!tx_busy) begin
`ifdef UART_TX_ARB_GAP_EN
            cnt   <= '0;
            state <= S_GAP;
`else
            state <= S_NEXT;
`endif
          end
        end
`ifdef UART_TX_ARB_GAP_EN
        S_GAP: begin
          if (baud_tick) begin
            if (cnt == CW'(GAP_TICKS - 1)) state <= S_NEXT;
            else                           cnt   <= cnt + 1'b1;
          end
        end
`endif
        S_NEXT: begin
          if (go_load) begin
            state <= S_LOAD;
          end else begin
            // A finished message releases silently. An owner that has
            // stopped offering bytes before its last one is an abort.
            err   <= ~last_q;
            grant <= 2'b00;
            ptr   <= ~ptr;
            state <= S_IDLE;
          end
        end
        default: begin
          grant <= 2'b00;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// ------------------
// Self-checking bench for uart_tx_arbiter. It contains a serializer model
// that drives tx_busy, queue-fed requesters, and a scoreboard of expected
// {owner, byte} pairs. The scoreboard is built from message-level
// round-robin rules.

module tb_uart_tx_arbiter;

  localparam int BUSY_WAIT_MAX = 16;
  localparam int GAP_TICKS     = 2;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       req0, last0, ack0;
  logic [7:0] data0;
  logic       req1, last1, ack1;
  logic [7:0] data1;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [1:0] grant;
  logic       err;

  uart_tx_arbiter #(
    .BUSY_WAIT_MAX (BUSY_WAIT_MAX),
    .GAP_TICKS     (GAP_TICKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .req0      (req0),
    .data0     (data0),
    .last0     (last0),
    .ack0      (ack0),
    .req1      (req1),
    .data1     (data1),
    .last1     (last1),
    .ack1      (ack1),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant     (grant),
    .err       (err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_ack0, n_ack1, n_err, err_cyc;
  int busy_left, frame_len, baud_cnt;
  bit busy_en, drv_en, sb_en, rand_frames, pend0, pend1;

  logic [8:0] rq0[$];     // {last, data} offered by requester 0
  logic [8:0] rq1[$];
  logic [8:0] exp_q[$];   // {owner, data} in expected consumption order
  int starts[$], falls[$], start_baud[$], fall_baud[$];

  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    logic [1:0] g;
    logic       a0, a1;
    logic [7:0] td;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, then update the
  // serializer model, baud ticks and requesters for the next edge.
  task automatic tick();
    logic [8:0] e;
    logic [1:0] eg;
    @(posedge clk);
    #1;
    cyc++;
    chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
    chk("start_with_ack", 32'(tx_start), 32'(ack0 | ack1));
    if (ack0) n_ack0++;
    if (ack1) n_ack1++;
    if (err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (tx_start) begin
      starts.push_back(cyc);
      start_baud.push_back(baud_cnt);
    end
    if (sb_en && (ack0 || ack1)) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_ack", 32'({ack1, ack0}), 32'd0);
      end else begin
        e  = exp_q.pop_front();
        eg = e[8] ? 2'b10 : 2'b01;
        chk("sb_owner", 32'({ack1, ack0}), 32'(eg));
        chk("sb_data", 32'(tx_data), 32'(e[7:0]));
        chk("sb_grant", 32'(grant), 32'(eg));
      end
    end
    // baud tick every 8 clocks
    baud_tick = (cyc % 8 == 0);
    if (baud_tick) baud_cnt++;
    // serializer model: busy for frame_len cycles starting with the tx_start cycle
    if (tx_start && busy_en) begin
      tx_busy   = 1'b1;
      busy_left = frame_len;
      if (rand_frames) frame_len = $urandom_range(3, 12);
    end else if (tx_busy) begin
      busy_left--;
      if (busy_left == 0) begin
        tx_busy = 1'b0;
        falls.push_back(cyc);
        fall_baud.push_back(baud_cnt);
      end
    end
    // requesters: hold the front byte through its ack cycle, drop it after
    if (drv_en) begin
      if (pend0) begin
        void'(rq0.pop_front());
        pend0 = 1'b0;
      end
      if (rq0.size() > 0) begin
        req0 = 1'b1; last0 = rq0[0][8]; data0 = rq0[0][7:0];
      end else begin
        req0 = 1'b0; last0 = 1'b0; data0 = 8'h00;
      end
      if (ack0) pend0 = 1'b1;
      if (pend1) begin
        void'(rq1.pop_front());
        pend1 = 1'b0;
      end
      if (rq1.size() > 0) begin
        req1 = 1'b1; last1 = rq1[0][8]; data1 = rq1[0][7:0];
      end else begin
        req1 = 1'b0; last1 = 1'b0; data1 = 8'h00;
      end
      if (ack1) pend1 = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drv_en = 1'b0; sb_en = 1'b0; rand_frames = 1'b0;
    rq0.delete(); rq1.delete(); exp_q.delete();
    pend0 = 1'b0; pend1 = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00; last0 = 1'b0; last1 = 1'b0;
    tx_busy = 1'b0; busy_left = 0;
    repeat (n) tick();
    rst = 1'b0;
    n_ack0 = 0; n_ack1 = 0; n_err = 0; err_cyc = 0;
    starts.delete(); falls.delete(); start_baud.delete(); fall_baud.delete();
  endtask

  task automatic run_until_idle(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (exp_q.size() == 0 && grant == 2'b00 && !tx_busy &&
          rq0.size() == 0 && rq1.size() == 0 && !pend0 && !pend1) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit found;
    int bad;
    int lens0[$], lens1[$];
    logic [7:0] dat0[$], dat1[$];
    int l0, l1, i0, i1, k0, k1;
    bit p, who;
    logic [7:0] d;

    baud_tick = 1'b0; rst = 1'b1; busy_en = 1'b1; frame_len = 10; baud_cnt = 0;
    do_reset(3);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_start", 32'(tx_start), 32'd0);
    chk("reset_txdata", 32'(tx_data), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // ---- reset in the middle of a frame ----
    drv_en = 1'b1;
    rq0.push_back({1'b1, 8'h5C});
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_start) break;
    end
    repeat (3) tick();
    chk("prerst_grant", 32'(grant), 32'd1);
    rst = 1'b1; drv_en = 1'b0; rq0.delete(); pend0 = 1'b0;
    req0 = 1'b0; last0 = 1'b0; data0 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_start", 32'(tx_start), 32'd0);
      chk("rst_acks", 32'({ack1, ack0}), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
    end
    rst = 1'b0;
    tick();
    chk("postrst_idle_grant", 32'(grant), 32'd0);
    chk("postrst_idle_err", 32'(err), 32'd0);
    req1 = 1'b1; data1 = 8'h3C; last1 = 1'b1;
    tick();
    chk("postrst_grant", 32'(grant), 32'd2);
    chk("postrst_start", 32'(tx_start), 32'd1);
    chk("postrst_data", 32'(tx_data), 32'h3C);
    req1 = 1'b0; data1 = 8'h00; last1 = 1'b0;

    // ---- table: first grant straight out of reset ----
    vecs[0] = '{1'b1, 1'b0, 8'h41, 8'h00, 2'b01, 1'b1, 1'b0, 8'h41};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h5A, 2'b10, 1'b0, 1'b1, 8'h5A};
    vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 2'b01, 1'b1, 1'b0, 8'h11};
    vecs[3] = '{1'b0, 1'b0, 8'h33, 8'h44, 2'b00, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'h00, 2'b01, 1'b1, 1'b0, 8'hFF};
    for (int v = 0; v < 5; v++) begin
      do_reset(2);
      req0 = vecs[v].r0; data0 = vecs[v].d0; last0 = 1'b1;
      req1 = vecs[v].r1; data1 = vecs[v].d1; last1 = 1'b1;
      tick();
      chk("vec_grant", 32'(grant), 32'(vecs[v].g));
      chk("vec_ack0", 32'(ack0), 32'(vecs[v].a0));
      chk("vec_ack1", 32'(ack1), 32'(vecs[v].a1));
      chk("vec_start", 32'(tx_start), 32'(vecs[v].a0 | vecs[v].a1));
      chk("vec_txdata", 32'(tx_data), 32'(vecs[v].td));
      req0 = 1'b0; req1 = 1'b0;
    end

    // ---- single 3-byte message ----
    do_reset(2);
    busy_en = 1'b1; frame_len = 10; drv_en = 1'b1; sb_en = 1'b1;
    rq0.push_back({1'b0, 8'h41}); rq0.push_back({1'b0, 8'h42}); rq0.push_back({1'b1, 8'h43});
    exp_q.push_back({1'b0, 8'h41}); exp_q.push_back({1'b0, 8'h42}); exp_q.push_back({1'b0, 8'h43});
    bad = 0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (n_ack0 >= 1 && n_ack0 < 3 && grant != 2'b01) bad++;
      if (exp_q.size() == 0 && grant == 2'b00 && !tx_busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("msg3_done", 32'(found), 32'd1);
    chk("msg3_grant_held", 32'(bad), 32'd0);
    chk("msg3_acks0", 32'(n_ack0), 32'd3);
    chk("msg3_acks1", 32'(n_ack1), 32'd0);
    chk("msg3_err", 32'(n_err), 32'd0);
    chk("msg3_txdata_hold", 32'(tx_data), 32'h43);
    chk("msg3_starts", 32'(starts.size()), 32'd3);
`ifdef UART_TX_ARB_GAP_EN
    chk("gap_ticks_1", 32'((start_baud[1] - fall_baud[0]) >= GAP_TICKS), 32'd1);
    chk("gap_ticks_2", 32'((start_baud[2] - fall_baud[1]) >= GAP_TICKS), 32'd1);
`else
    chk("b2b_latency_1", 32'(starts[1] - falls[0]), 32'd2);
    chk("b2b_latency_2", 32'(starts[2] - falls[1]), 32'd2);
`endif

    // ---- contention: two simultaneous pairs of 1-byte messages ----
    do_reset(2);
    busy_en = 1'b1; frame_len = 5; drv_en = 1'b1; sb_en = 1'b1;
    rq0.push_back({1'b1, 8'hA0}); rq1.push_back({1'b1, 8'hB0});
    exp_q.push_back({1'b0, 8'hA0}); exp_q.push_back({1'b1, 8'hB0});
    run_until_idle("cont_pair1_done", 200);
    rq0.push_back({1'b1, 8'hA1}); rq1.push_back({1'b1, 8'hB1});
    exp_q.push_back({1'b0, 8'hA1}); exp_q.push_back({1'b1, 8'hB1});
    run_until_idle("cont_pair2_done", 200);
    chk("cont_err", 32'(n_err), 32'd0);

    // ---- busy-rise timeout ----
    do_reset(2);
    busy_en = 1'b0; drv_en = 1'b1; sb_en = 1'b1;
    rq0.push_back({1'b1, 8'h77});
    exp_q.push_back({1'b0, 8'h77});
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (err) begin
        found = 1'b1;
        break;
      end
    end
    chk("to_seen", 32'(found), 32'd1);
    chk("to_latency", 32'(err_cyc - starts[0]), 32'(BUSY_WAIT_MAX + 1));
    chk("to_grant", 32'(grant), 32'd0);
    tick();
    chk("to_err_pulse", 32'(err), 32'd0);
    chk("to_acks", 32'(n_ack0), 32'd1);
    // pointer moved to requester 1 after the timeout
    busy_en = 1'b1; frame_len = 4;
    rq0.push_back({1'b1, 8'hC0}); rq1.push_back({1'b1, 8'hC1});
    exp_q.push_back({1'b1, 8'hC1}); exp_q.push_back({1'b0, 8'hC0});
    run_until_idle("to_after_done", 200);
    chk("to_err_count", 32'(n_err), 32'd1);

    // ---- abort: requester 1 drops after the first of two bytes ----
    do_reset(2);
    busy_en = 1'b1; frame_len = 6; drv_en = 1'b1; sb_en = 1'b1;
    rq1.push_back({1'b0, 8'h61});
    exp_q.push_back({1'b1, 8'h61});
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (err) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_seen", 32'(found), 32'd1);
`ifdef UART_TX_ARB_GAP_EN
    chk("abort_after_fall", 32'(err_cyc > falls[0]), 32'd1);
`else
    chk("abort_latency", 32'(err_cyc - falls[0]), 32'd2);
`endif
    chk("abort_grant", 32'(grant), 32'd0);
    repeat (5) tick();
    chk("abort_acks1", 32'(n_ack1), 32'd1);
    chk("abort_err_count", 32'(n_err), 32'd1);

    // ---- random messages, both requesters always pending ----
    do_reset(2);
    busy_en = 1'b1; frame_len = 6; rand_frames = 1'b1; drv_en = 1'b1; sb_en = 1'b1;
    for (int m = 0; m < 6; m++) begin
      l0 = $urandom_range(1, 3);
      l1 = $urandom_range(1, 3);
      lens0.push_back(l0);
      lens1.push_back(l1);
      for (int b = 0; b < l0; b++) begin
        d = 8'($urandom);
        dat0.push_back(d);
        rq0.push_back({(b == l0 - 1), d});
      end
      for (int b = 0; b < l1; b++) begin
        d = 8'($urandom);
        dat1.push_back(d);
        rq1.push_back({(b == l1 - 1), d});
      end
    end
    // whole messages alternate by the pointer, which flips after every message
    i0 = 0; i1 = 0; k0 = 0; k1 = 0; p = 1'b0;
    while (i0 < 6 || i1 < 6) begin
      if (i0 < 6 && i1 < 6) who = p;
      else                  who = (i0 < 6) ? 1'b0 : 1'b1;
      if (!who) begin
        for (int b = 0; b < lens0[i0]; b++) begin
          exp_q.push_back({1'b0, dat0[k0]});
          k0++;
        end
        i0++;
      end else begin
        for (int b = 0; b < lens1[i1]; b++) begin
          exp_q.push_back({1'b1, dat1[k1]});
          k1++;
        end
        i1++;
      end
      p = ~p;
    end
    run_until_idle("rand_done", 6000);
    chk("rand_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_err", 32'(n_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Sequences byte messages from two requesters onto the single UART transmitter.
- Arbitrates round-robin at message boundaries and holds a grant until the message's last byte.
- Drives the transmitter's data and start controls, tracks its busy flag, and reports timeouts and aborted messages.
- Sits between the DDS register controller (requester 0), the command-echo path (requester 1) and the UART TX serializer.

Parameters:
BUSY_WAIT_MAX, 16, clk cycles allowed after tx_start for tx_busy to rise before timeout
GAP_TICKS, 2, baud ticks of idle inserted between frames (used only with optional feature)

Ports:
clk  in  1  general clock
rst  in  1  synchronous reset, active-high
baud_tick  in  1  one-clk pulse per baud period
req0  in  1  requester 0 has a byte valid
data0  in  8  requester 0 byte
last0  in  1  requester 0 byte is end of message
ack0  out  1  one-clk pulse: requester 0 byte consumed
req1  in  1  requester 1 has a byte valid
data1  in  8  requester 1 byte
last1  in  1  requester 1 byte is end of message
ack1  out  1  one-clk pulse: requester 1 byte consumed
tx_data  out  8  byte to transmitter, stable from tx_start until frame done
tx_start  out  1  one-clk pulse: start frame
tx_busy  in  1  transmitter sending a frame
grant  out  2  one-hot current owner, 00 = none
err  out  1  one-clk pulse on timeout or abort

Behaviour:
- Reset: all outputs 0; state IDLE; priority pointer = requester 0.
- A synchronous rst in any state returns to IDLE next edge with no ack or err pulse.
- IDLE, no req: stay in IDLE.
- IDLE, single req: grant that requester.
- IDLE, both req: grant the pointer's requester; pointer toggles only when a message completes or aborts.
- IDLE exit: grant is set in the same cycle; next state is LOAD.
- LOAD (1 cycle): latch data/last of the owner into tx_data and an internal last flag; pulse ack(owner) and tx_start; go WAIT_RISE.
- WAIT_RISE: count cycles from 0.
  - tx_busy=1: go WAIT_FALL.
  - Count reaches BUSY_WAIT_MAX with tx_busy still 0: pulse err, clear grant, toggle pointer, go IDLE.
- WAIT_FALL: on tx_busy=0, go NEXT (GAP if feature enabled).
- NEXT (1 cycle):
  - Latched last=1: clear grant, toggle pointer, go IDLE.
  - Else owner req=1: go LOAD.
  - Else (owner dropped req mid-message): pulse err, clear grant, toggle pointer, go IDLE.
- Latency: req to tx_start is 2 cycles from IDLE (IDLE, LOAD); back-to-back bytes give tx_start 2 cycles after tx_busy falls.
- Requester rules:
  - Requester holds req/data/last stable until its ack.
  - Input values during the ack cycle are the consumed byte; the next byte may be presented the following cycle.
- Non-owner req is ignored while a grant is held and is never acked.
- ack0 and ack1 are never high together; tx_start coincides with ack.
- tx_data holds its value after the frame until the next LOAD.

Optional Feature:
- UART_TX_ARB_GAP_EN defined:
  - WAIT_FALL goes to GAP, which counts baud_tick pulses.
  - After GAP_TICKS ticks, go NEXT.
  - Only rst aborts GAP.
- Undefined: GAP state absent, WAIT_FALL goes directly to NEXT, baud_tick unused.

Test Plan:
- Reset: rst high 3 cycles mid-WAIT_FALL -> grant=00, tx_start=0, ack0/1=0, err=0; IDLE next cycle.
- Single 3-byte message: req0 with 0x41,0x42,0x43 (last on 0x43), model tx_busy 10 cycles/frame -> three ack0 pulses, tx_data sequence 41,42,43, grant 01 throughout, then 00.
- Contention: req0 and req1 both high from reset, each 1-byte message -> requester 0 served first, then requester 1; a second simultaneous pair is again served 0 then 1 (pointer toggled twice); no interleaving.
- Timeout: tx_busy tied 0, BUSY_WAIT_MAX=16 -> err pulse exactly 16 cycles after WAIT_RISE entry, grant=00.
- Abort: req1 drops after the first of 2 bytes -> err pulse in NEXT, grant=00, only one ack1.
- Gap (UART_TX_ARB_GAP_EN, GAP_TICKS=2, baud_tick every 8 clks) -> second tx_start no earlier than 2 baud ticks after tx_busy falls.
